// File: rtl/mux4_rr_sel_pkg.sv
// Shared types for the 4-channel round-robin mux select controller.
// Channel index, FSM state and one-hot grant helper.
package mux4_pkg;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef logic [1:0] ch_idx_t;

  localparam int NUM_CH = 4;

  function automatic logic [NUM_CH-1:0] onehot4(input ch_idx_t idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_sel_pick.sv
// Combinational round-robin picker: first requester at or after start.
// Rotate so start sits at bit 0, priority-encode, then un-rotate.
module rr_pick4
  import mux4_pkg::*;
(
  input  logic [3:0] req,
  input  ch_idx_t    start,
  output ch_idx_t    pick,
  output logic       any
);

  logic [7:0] w_dbl;
  logic [3:0] w_rot;
  ch_idx_t    w_off;

  assign w_dbl = {req, req} >> start;
  assign w_rot = w_dbl[3:0];

  // Lowest set bit of the rotated vector is the closest requester.
  always_comb begin
    w_off = 2'd0;
    priority case (1'b1)
      w_rot[0]: w_off = 2'd0;
      w_rot[1]: w_off = 2'd1;
      w_rot[2]: w_off = 2'd2;
      w_rot[3]: w_off = 2'd3;
      default:  w_off = 2'd0;
    endcase
  end

  assign pick = start + w_off;
  assign any  = |req;

endmodule

// File: rtl/mux4_rr_sel.sv
// Round-robin select controller driving a 4:1 mux with Valid/Ack handshake.
// Define RR_ARB_BURST_EN to hold each grant for up to BURST_LEN transfers.
module mux4_rr_sel
  import mux4_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 3
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] Req,
  input  logic       Ack,
  output logic       Sel1,
  output logic       Sel0,
  output logic [3:0] Grant,
  output logic       Valid
);

  if (2 ** CNT_W <= BURST_LEN) begin : g_bad_cnt_w
    $error("CNT_W too narrow for BURST_LEN");
  end

  state_t     r_state;
  ch_idx_t    r_sel;
  ch_idx_t    r_last;
  logic [3:0] r_grant;
  logic       r_valid;

  ch_idx_t    w_start;
  ch_idx_t    w_pick;
  logic       w_any;
  logic       w_hit;
  logic       w_xfer;
  logic       w_last_beat;
  logic       w_load;

  // IDLE scans after the last completed channel, BUSY after the current one.
  assign w_start = (r_state == IDLE) ? r_last + 2'd1
                                     : r_sel + 2'd1;

  rr_pick4 u_pick (
    .req   (Req),
    .start (w_start),
    .pick  (w_pick),
    .any   (w_any)
  );

  assign w_hit  = Req[r_sel];
  assign w_xfer = (r_state == BUSY) && w_hit && Ack;

`ifdef RR_ARB_BURST_EN
  logic [CNT_W-1:0] r_cnt;

  assign w_last_beat = (r_cnt == CNT_W'(BURST_LEN - 1));

  // Beats within the current grant; restarts whenever a grant is loaded.
  always_ff @(posedge Clk) begin
    if (Rst)
      r_cnt <= '0;
    else if (w_load)
      r_cnt <= '0;
    else if (w_xfer)
      r_cnt <= r_cnt + CNT_W'(1);
  end
`else
  assign w_last_beat = 1'b1;
`endif

  assign w_load = ((r_state == IDLE) && w_any)
               || (w_xfer && w_last_beat && w_any);

  // Grant FSM: select lines move only when a new grant is loaded.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= IDLE;
      r_sel   <= 2'd0;
      r_last  <= 2'd3;
      r_grant <= 4'b0000;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_load) begin
            r_sel   <= w_pick;
            r_grant <= onehot4(w_pick);
            r_valid <= 1'b1;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (!w_hit) begin
            r_grant <= 4'b0000;
            r_valid <= 1'b0;
            r_state <= IDLE;
          end else if (Ack && w_last_beat) begin
            r_last <= r_sel;
            if (w_load) begin
              r_sel   <= w_pick;
              r_grant <= onehot4(w_pick);
            end else begin
              r_grant <= 4'b0000;
              r_valid <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Sel1  = r_sel[1];
  assign Sel0  = r_sel[0];
  assign Grant = r_grant;
  assign Valid = r_valid;

endmodule

// File: tb/tb_mux4_rr_sel.sv
// Scoreboard bench for mux4_rr_sel: directed vectors, queued expectations.
// Define RR_ARB_BURST_EN to run the burst sequence instead.
module tb_mux4_rr_sel;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [3:0] Req = 4'b0000;
  logic       Ack = 1'b0;
  logic       Sel1;
  logic       Sel0;
  logic [3:0] Grant;
  logic       Valid;

  typedef struct packed {
    logic       v;
    logic [3:0] g;
    logic [1:0] s;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec    = 0;

  mux4_rr_sel dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Req   (Req),
    .Ack   (Ack),
    .Sel1  (Sel1),
    .Sel0  (Sel0),
    .Grant (Grant),
    .Valid (Valid)
  );

  always #5 Clk = ~Clk;

  task automatic step(input logic rst, input logic [3:0] req,
                      input logic ack, input logic v,
                      input logic [3:0] g, input logic [1:0] s);
    exp_t e;
    @(negedge Clk);
    #1;
    Rst = rst;
    Req = req;
    Ack = ack;
    @(posedge Clk);
    e.v = v;
    e.g = g;
    e.s = s;
    q.push_back(e);
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({Valid, Grant, Sel1, Sel0} !== e) begin
        errors++;
        $display("FAIL vec%0d got V=%b G=%b S=%b%b exp V=%b G=%b S=%b",
                 vec, Valid, Grant, Sel1, Sel0, e.v, e.g, e.s);
      end
      vec++;
    end
  end

  initial begin
    // reset held with all requesting
    step(1, 4'b1111, 0, 0, 4'b0000, 2'b00);
    step(1, 4'b1111, 0, 0, 4'b0000, 2'b00);
`ifdef RR_ARB_BURST_EN
    step(0, 4'b0011, 1, 1, 4'b0001, 2'b00);
    for (int i = 0; i < 3; i++)
      step(0, 4'b0011, 1, 1, 4'b0001, 2'b00);
    for (int i = 0; i < 4; i++)
      step(0, 4'b0011, 1, 1, 4'b0010, 2'b01);
    step(0, 4'b0011, 1, 1, 4'b0001, 2'b00);
    // abort mid-burst
    step(0, 4'b0010, 1, 0, 4'b0000, 2'b00);
    step(0, 4'b0010, 0, 1, 4'b0010, 2'b01);
`else
    // first grant after release
    step(0, 4'b1111, 0, 1, 4'b0001, 2'b00);
    // fairness rotation
    step(0, 4'b1111, 1, 1, 4'b0010, 2'b01);
    step(0, 4'b1111, 1, 1, 4'b0100, 2'b10);
    step(0, 4'b1111, 1, 1, 4'b1000, 2'b11);
    step(0, 4'b1111, 1, 1, 4'b0001, 2'b00);
    // abort ch0, then grant ch2 and stall
    step(0, 4'b0100, 1, 0, 4'b0000, 2'b00);
    step(0, 4'b0100, 0, 1, 4'b0100, 2'b10);
    for (int i = 0; i < 5; i++)
      step(0, 4'b0100, 0, 1, 4'b0100, 2'b10);
    step(0, 4'b0000, 1, 0, 4'b0000, 2'b10);
    // ack while idle is ignored
    step(0, 4'b0000, 1, 0, 4'b0000, 2'b10);
    // build Last=0, grant ch1, abort it
    step(0, 4'b0001, 0, 1, 4'b0001, 2'b00);
    step(0, 4'b0011, 1, 1, 4'b0010, 2'b01);
    step(0, 4'b0001, 1, 0, 4'b0000, 2'b01);
    step(0, 4'b0001, 0, 1, 4'b0001, 2'b00);
    // skip idle channels
    step(0, 4'b1001, 1, 1, 4'b1000, 2'b11);
    step(0, 4'b1001, 1, 1, 4'b0001, 2'b00);
    step(0, 4'b1001, 1, 1, 4'b1000, 2'b11);
    // lone requester wins again
    step(0, 4'b1000, 1, 1, 4'b1000, 2'b11);
    step(0, 4'b0000, 1, 0, 4'b0000, 2'b11);
    step(0, 4'b0010, 0, 1, 4'b0010, 2'b01);
    // reset while busy
    step(1, 4'b1111, 1, 0, 4'b0000, 2'b00);
    step(0, 4'b0100, 0, 1, 4'b0100, 2'b10);
`endif
    repeat (3) @(negedge Clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
